fft16_ofdm_core: RTL and testbench

16-point radix-2 decimation-in-time FFT for the OFDM receive path. It collects 16 real byte samples from the UART receiver and computes the transform with one butterfly per clock. It then presents all 16 complex bins on flattened output buses and pulses a done strobe, which starts the UART transmit sequencer.

---
 rtl/fft16_pkg.sv | 37 +++
 rtl/fft16_if.sv | 22 ++
 rtl/fft16_butterfly.sv | 48 ++++
 rtl/fft16_ofdm_core.sv | 105 ++++++++++
 tb/tb_fft16_ofdm_core.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fft16_pkg.sv
// rtl/fft16_pkg.sv - shared constants, types, twiddle ROM and bit-reverse helper for the 16-point FFT
package fft16_pkg;

  localparam int FFT_SIZE    = 16;
  localparam int WORD_SIZE   = 16;
  localparam int DATA_LENGTH = 8;
  localparam int FRACTION    = 8;
  localparam int STAGES      = 4;

  typedef struct packed {
    logic signed [WORD_SIZE-1:0] re;
    logic signed [WORD_SIZE-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q8.8
  localparam cplx_t [0:7] TWIDDLE = '{
    '{re:  16'sd256, im:  16'sd0  },
    '{re:  16'sd237, im: -16'sd98 },
    '{re:  16'sd181, im: -16'sd181},
    '{re:  16'sd98,  im: -16'sd237},
    '{re:  16'sd0,   im: -16'sd256},
    '{re: -16'sd98,  im: -16'sd237},
    '{re: -16'sd181, im: -16'sd181},
    '{re: -16'sd237, im: -16'sd98 }
  };

  function automatic logic [3:0] bit_reverse(input logic [3:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

endpackage

// File: rtl/fft16_if.sv
// rtl/fft16_if.sv - sample input and flattened spectrum output bundle of the 16-point FFT core
interface fft16_if;
  import fft16_pkg::*;

  logic [DATA_LENGTH-1:0]        i_byte;
  logic                          i_byte_valid;
  logic [FFT_SIZE*WORD_SIZE-1:0] o_re;
  logic [FFT_SIZE*WORD_SIZE-1:0] o_im;
  logic                          o_fft_cycle_done;
  logic                          o_busy;

  modport master (
    output i_byte, i_byte_valid,
    input  o_re, o_im, o_fft_cycle_done, o_busy
  );

  modport slave (
    input  i_byte, i_byte_valid,
    output o_re, o_im, o_fft_cycle_done, o_busy
  );

endinterface

// File: rtl/fft16_butterfly.sv
// rtl/fft16_butterfly.sv - combinational radix-2 DIT butterfly: a' = a + b*w, b' = a - b*w
// FFT16_STAGE_SCALE_EN: halve each output so the full transform is scaled by 1/16.
module fft16_butterfly
  import fft16_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t tw,
  output cplx_t a_out,
  output cplx_t b_out
);

  logic signed [2*WORD_SIZE-1:0] t_re_full, t_im_full;
  logic signed [2*WORD_SIZE-1:0] t_re_shift, t_im_shift;
  logic signed [WORD_SIZE-1:0]   t_re, t_im;
  logic signed [WORD_SIZE:0]     s_re, s_im, d_re, d_im;
  logic                          unused_bits;

  always_comb begin
    t_re_full  = $signed(b.re) * $signed(tw.re) - $signed(b.im) * $signed(tw.im);
    t_im_full  = $signed(b.re) * $signed(tw.im) + $signed(b.im) * $signed(tw.re);
    t_re_shift = t_re_full >>> FRACTION;
    t_im_shift = t_im_full >>> FRACTION;
    t_re       = t_re_shift[WORD_SIZE-1:0];
    t_im       = t_im_shift[WORD_SIZE-1:0];

    // one guard bit so the scaled variant keeps the carry
    s_re = {a.re[WORD_SIZE-1], a.re} + {t_re[WORD_SIZE-1], t_re};
    s_im = {a.im[WORD_SIZE-1], a.im} + {t_im[WORD_SIZE-1], t_im};
    d_re = {a.re[WORD_SIZE-1], a.re} - {t_re[WORD_SIZE-1], t_re};
    d_im = {a.im[WORD_SIZE-1], a.im} - {t_im[WORD_SIZE-1], t_im};

`ifdef FFT16_STAGE_SCALE_EN
    a_out.re = s_re[WORD_SIZE:1];
    a_out.im = s_im[WORD_SIZE:1];
    b_out.re = d_re[WORD_SIZE:1];
    b_out.im = d_im[WORD_SIZE:1];
`else
    a_out.re = s_re[WORD_SIZE-1:0];
    a_out.im = s_im[WORD_SIZE-1:0];
    b_out.re = d_re[WORD_SIZE-1:0];
    b_out.im = d_im[WORD_SIZE-1:0];
`endif
  end

  assign unused_bits = ^{t_re_shift, t_im_shift, s_re, s_im, d_re, d_im};

endmodule

// File: rtl/fft16_ofdm_core.sv
// rtl/fft16_ofdm_core.sv - 16-point in-place DIT FFT: capture 16 bytes, 32 butterflies, publish bins
// Per-stage scaling is selected by FFT16_STAGE_SCALE_EN inside fft16_butterfly.
module fft16_ofdm_core
  import fft16_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  fft16_if.slave bus
);

  localparam int STAGE_W = $clog2(STAGES);

  state_t                        state;
  logic [3:0]                    sample_cnt;
  logic [STAGE_W-1:0]            stage;
  logic [2:0]                    bf;
  cplx_t                         mem [FFT_SIZE];
  logic [3:0]                    top_idx, bot_idx;
  logic [2:0]                    tw_idx;
  cplx_t                         bf_a_out, bf_b_out;
  cplx_t                         sample_word;
  logic [FFT_SIZE*WORD_SIZE-1:0] re_q, im_q;
  logic                          done_q, busy_q;

  // butterfly bf of stage s: group bf>>s, position j = bf mod 2^s, partner at +2^s
  always_comb begin
    top_idx = '0;
    tw_idx  = '0;
    case (stage)
      2'd0:    begin top_idx = {bf, 1'b0};               tw_idx = 3'd0;             end
      2'd1:    begin top_idx = {bf[2:1], 1'b0, bf[0]};   tw_idx = {bf[0], 2'b00};   end
      2'd2:    begin top_idx = {bf[2], 1'b0, bf[1:0]};   tw_idx = {bf[1:0], 1'b0};  end
      default: begin top_idx = {1'b0, bf};               tw_idx = bf;               end
    endcase
    bot_idx = top_idx | (4'd1 << stage);
  end

  always_comb begin
    sample_word    = '0;
    sample_word.re = {bus.i_byte, {FRACTION{1'b0}}};
  end

  fft16_butterfly u_butterfly (
    .a     (mem[top_idx]),
    .b     (mem[bot_idx]),
    .tw    (TWIDDLE[tw_idx]),
    .a_out (bf_a_out),
    .b_out (bf_b_out)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= CAPTURE;
      sample_cnt <= '0;
      stage      <= '0;
      bf         <= '0;
      for (int k = 0; k < FFT_SIZE; k++) mem[k] <= '0;
      re_q       <= '0;
      im_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        CAPTURE: begin
          if (bus.i_byte_valid) begin
            mem[bit_reverse(sample_cnt)] <= sample_word;
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == 4'd15) begin
              state  <= COMPUTE;
              busy_q <= 1'b1;
              stage  <= '0;
              bf     <= '0;
            end
          end
        end
        COMPUTE: begin
          mem[top_idx] <= bf_a_out;
          mem[bot_idx] <= bf_b_out;
          bf           <= bf + 3'd1;
          if (bf == 3'd7) begin
            stage <= stage + 1'b1;
            if (stage == STAGE_W'(STAGES - 1)) state <= DONE;
          end
        end
        DONE: begin
          for (int k = 0; k < FFT_SIZE; k++) begin
            re_q[k*WORD_SIZE +: WORD_SIZE] <= mem[k].re;
            im_q[k*WORD_SIZE +: WORD_SIZE] <= mem[k].im;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= CAPTURE;
        end
        default: state <= CAPTURE;
      endcase
    end
  end

  assign bus.o_re             = re_q;
  assign bus.o_im             = im_q;
  assign bus.o_fft_cycle_done = done_q;
  assign bus.o_busy           = busy_q;

endmodule

// File: tb/tb_fft16_ofdm_core.sv
// tb/tb_fft16_ofdm_core.sv - scoreboard bench for fft16_ofdm_core (expectations follow FFT16_STAGE_SCALE_EN)
module tb_fft16_ofdm_core;

`ifdef FFT16_STAGE_SCALE_EN
  localparam logic [7:0]  AMP     = 8'h10;
  localparam logic [7:0]  NEG     = 8'hF0;
  localparam logic [15:0] IMP_BIN = 16'h0010;
  localparam logic [15:0] PEAK    = 16'h1000;
`else
  localparam logic [7:0]  AMP     = 8'h07;
  localparam logic [7:0]  NEG     = 8'hF9;
  localparam logic [15:0] IMP_BIN = 16'h0100;
  localparam logic [15:0] PEAK    = 16'h7000;
`endif
  localparam int LATENCY = 34;

  typedef struct {
    logic [255:0] re;
    logic [255:0] im;
    int           tol;
    int           peak;
    int           e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   exp_done = 0;
  exp_t sb [$];

  logic [255:0] imp_re, dc_re, nyq_re;
  logic [127:0] imp_smp, dc_smp, nyq_smp;

  fft16_if bus_if ();

  fft16_ofdm_core dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus_if.i_byte       = b;
    bus_if.i_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.i_byte_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [127:0] smp, input logic [255:0] ere, input int tol,
                           input int peak, input bit expect_done, input int junk);
    exp_t e;
    for (int k = 0; k < 16; k++) send_byte(smp[k*8 +: 8]);
    if (expect_done) begin
      e.re = ere; e.im = '0; e.tol = tol; e.peak = peak; e.e0 = cyc;
      sb.push_back(e);
      exp_done++;
    end
    for (int j = 0; j < junk; j++) send_byte(8'h55);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && n_done < exp_done; i++) @(negedge clk);
    checks++;
    if (n_done < exp_done) begin
      errors++;
      $display("FAIL %s_timeout: done count %0d expected %0d", name, n_done, exp_done);
    end
  endtask

  // monitor: compares every published spectrum against the oldest expected frame
  initial begin
    exp_t e;
    logic signed [15:0] av, ev;
    int d, tol;
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        checks++;
        if (bus_if.o_fft_cycle_done !== 1'b0) begin
          errors++;
          $display("FAIL done_width: done still %b one cycle later, expected 0", bus_if.o_fft_cycle_done);
        end
      end
      if (bus_if.o_fft_cycle_done === 1'b1) begin
        n_done++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done pulse at cycle %0d with no frame outstanding", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc - e.e0 + 1 != LATENCY) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc - e.e0 + 1, LATENCY);
          end
          for (int k = 0; k < 16; k++) begin
            tol = (k == e.peak) ? 0 : e.tol;
            av = bus_if.o_re[k*16 +: 16]; ev = e.re[k*16 +: 16]; d = av - ev;
            checks++;
            if (d > tol || d < -tol) begin
              errors++;
              $display("FAIL re_bin%0d: got %h expected %h (tol %0d)", k, av, ev, tol);
            end
            av = bus_if.o_im[k*16 +: 16]; ev = e.im[k*16 +: 16]; d = av - ev;
            checks++;
            if (d > tol || d < -tol) begin
              errors++;
              $display("FAIL im_bin%0d: got %h expected %h (tol %0d)", k, av, ev, tol);
            end
          end
        end
      end
      prev_done = (bus_if.o_fft_cycle_done === 1'b1);
    end
  end

  initial begin
    int nd;
    bus_if.i_byte       = '0;
    bus_if.i_byte_valid = 1'b0;

    imp_smp = 128'h01;
    dc_smp  = {16{AMP}};
    nyq_smp = {8{NEG, AMP}};
    imp_re  = {16{IMP_BIN}};
    dc_re   = {240'b0, PEAK};
    nyq_re  = {112'b0, PEAK, 128'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_re", bus_if.o_re, '0);
    check("reset_im", bus_if.o_im, '0);
    check("reset_done", {255'b0, bus_if.o_fft_cycle_done}, '0);
    check("reset_busy", {255'b0, bus_if.o_busy}, '0);

    // impulse, then DC back-to-back with junk strobes during compute
    run_frame(imp_smp, imp_re, 0, -1, 1'b1, 0);
    @(negedge clk);
    check("busy_in_compute", {255'b0, bus_if.o_busy}, 256'd1);
    wait_done("impulse");
    @(negedge clk);
    check("busy_after_done", {255'b0, bus_if.o_busy}, '0);

    run_frame(dc_smp, dc_re, 0, 0, 1'b1, 5);
    check("hold_re", bus_if.o_re, imp_re);
    check("hold_im", bus_if.o_im, '0);
    wait_done("dc");

    run_frame(nyq_smp, nyq_re, 2, 8, 1'b1, 0);
    wait_done("nyquist");

    // reset at E10 aborts the frame without a done pulse
    run_frame(dc_smp, dc_re, 0, 0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    nd = n_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_re", bus_if.o_re, '0);
    check("abort_im", bus_if.o_im, '0);
    check("abort_busy", {255'b0, bus_if.o_busy}, '0);
    repeat (50) @(negedge clk);
    check("abort_no_done", 256'(n_done), 256'(nd));

    run_frame(dc_smp, dc_re, 0, 0, 1'b1, 0);
    wait_done("dc_after_reset");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 256'(sb.size()), '0);
    check("done_count", 256'(n_done), 256'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
